// File: rtl/bsg_clk_div_pkg.sv
// Shared types and default sizing for the programmable clock-divider bank.
package bsg_clk_div_pkg;

  localparam int bsg_clk_div_width_gp     = 16;
  localparam int bsg_clk_div_div_width_gp = 8;

  typedef struct packed {
    logic                                en;
    logic [bsg_clk_div_div_width_gp-1:0] div;
  } bsg_clk_div_cfg_s;

endpackage

// File: rtl/bsg_clk_div_lane.sv
// One divider lane: toggles its output every div_r+1 cycles and only accepts a
// new configuration at a point where swapping it in cannot produce a runt pulse.
module bsg_clk_div_lane
  import bsg_clk_div_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             apply_i,
  input  bsg_clk_div_cfg_s cfg_i,
  output logic             clk_o,
  output logic             safe_o
);

  logic                                en_r;
  logic [bsg_clk_div_div_width_gp-1:0] div_r;
  logic [bsg_clk_div_div_width_gp-1:0] cnt_r;
  logic                                out_r;
  logic                                at_top;

  assign at_top = (cnt_r == div_r);

  // Applying while high and about to fall makes the apply coincide with the natural falling edge.
  assign safe_o = ~en_r | (at_top & out_r);
  assign clk_o  = out_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      en_r  <= 1'b0;
      div_r <= '0;
      cnt_r <= '0;
      out_r <= 1'b0;
    end else if (apply_i) begin
      en_r  <= cfg_i.en;
      div_r <= cfg_i.div;
      cnt_r <= '0;
      out_r <= 1'b0;
    end else if (en_r) begin
      if (at_top) begin
        cnt_r <= '0;
        out_r <= ~out_r;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end else begin
      cnt_r <= '0;
      out_r <= 1'b0;
    end
  end

endmodule

// File: rtl/bsg_clk_div_bank.sv
// Bank of independently programmable clock dividers sharing a single
// outstanding-configuration slot that is applied at each lane's safe point.
module bsg_clk_div_bank
  import bsg_clk_div_pkg::*;
#(
  parameter  int width_p          = bsg_clk_div_width_gp,
  parameter  int div_width_p      = bsg_clk_div_div_width_gp,
  localparam int lane_id_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        cfg_v_i,
  input  logic [lane_id_width_lp-1:0] cfg_lane_i,
  input  logic                        cfg_en_i,
  input  logic [div_width_p-1:0]      cfg_div_i,
  output logic                        cfg_ready_o,
  output logic [width_p-1:0]          clk_o
);

  logic                        pending_r;
  logic [lane_id_width_lp-1:0] pending_lane_r;
  bsg_clk_div_cfg_s            pending_cfg_r;

  logic [width_p-1:0] lane_safe;
  logic [width_p-1:0] lane_apply;
  logic               accept;
  logic               lane_in_range;
  logic               target_safe;
  logic               apply_now;
  logic               drop_now;

  assign cfg_ready_o   = ~pending_r;
  assign accept        = cfg_v_i & ~pending_r;
  assign lane_in_range = (32'(pending_lane_r) < width_p);

  always_comb begin
    target_safe = 1'b0;
    for (int k = 0; k < width_p; k++) begin
      if (pending_lane_r == lane_id_width_lp'(k)) begin
        target_safe = lane_safe[k];
      end
    end
  end

  // Selects that name no physical lane are discarded so the slot never wedges.
  assign apply_now = pending_r & lane_in_range & target_safe;
  assign drop_now  = pending_r & ~lane_in_range;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_r      <= 1'b0;
      pending_lane_r <= '0;
      pending_cfg_r  <= '0;
    end else if (accept) begin
      pending_r      <= 1'b1;
      pending_lane_r <= cfg_lane_i;
      pending_cfg_r  <= '{en: cfg_en_i, div: cfg_div_i};
    end else if (apply_now | drop_now) begin
      pending_r      <= 1'b0;
    end
  end

  for (genvar k = 0; k < width_p; k++) begin : g_lane
    assign lane_apply[k] = apply_now & (pending_lane_r == lane_id_width_lp'(k));

    bsg_clk_div_lane u_lane (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .apply_i   (lane_apply[k]),
      .cfg_i     (pending_cfg_r),
      .clk_o     (clk_o[k]),
      .safe_o    (lane_safe[k])
    );
  end

endmodule

// File: doc/bsg_clk_div_bank.md
Name: bsg_clk_div_bank

Overview:
- Bank of `width_p` independently programmable clock dividers running off one reference clock.
- Produces the `width_p`-bit clock vector that feeds the clock-buffer stage directly downstream. Each output bit goes to one buffer lane.
- Lane configuration arrives through a valid/ready port.
- A new configuration takes effect only at a glitch-free boundary, so no runt pulse ever reaches the buffers during normal operation.

Parameters:
- `width_p`, 16, number of divider lanes (output vector width).
- `div_width_p`, 8, width of the per-lane divide field.
- `lane_id_width_lp`, `$clog2(width_p)` (localparam), width of the lane select.

Ports:
- `clk_i`  in  1  reference clock.
- `reset_n_i`  in  1  reset, asynchronous, active-low.
- `cfg_v_i`  in  1  configuration valid.
- `cfg_lane_i`  in  `lane_id_width_lp`  target lane.
- `cfg_en_i`  in  1  lane enable value.
- `cfg_div_i`  in  `div_width_p`  divide value D; output period is 2*(D+1) `clk_i` cycles.
- `cfg_ready_o`  out  1  configuration slot free.
- `clk_o`  out  `width_p`  divided clocks, registered, one per lane.

Behaviour:
- Clocking and reset:
  - One clock, `clk_i`.
  - Reset is asynchronous, active-low, on `reset_n_i`.
  - While `reset_n_i`=0, all lane state clears immediately: `en`=0, `div_r`=0, `cnt`=0, `clk_o`=0 for every lane, `pending`=0, `cfg_ready_o`=1.
- Per-lane state: `en`, `div_r[div_width_p]`, `cnt[div_width_p]`, `out`. `clk_o[k]` = `out` of lane k (a flop output; no combinational path to `clk_o`).
- Enabled lane, each cycle:
  - if `cnt`==`div_r`: `cnt`<=0 and `out`<=~`out`;
  - else `cnt`<=`cnt`+1.
  - Result: low and high phases of exactly D+1 cycles each, 50% duty. D=0 gives divide-by-2.
- Disabled lane: `out` held 0, `cnt` held 0.
- Configuration handshake:
  - Accept when `cfg_v_i` & `cfg_ready_o`.
  - On accept, a single global pending register captures lane, en and div, and sets `pending`=1.
  - `cfg_ready_o` = ~`pending`; it does not depend on `cfg_v_i`.
- Safe point for lane k is either of:
  - lane disabled;
  - `en` & (`cnt`==`div_r`) & (`out`==1), i.e. the cycle before the natural falling edge.
- Apply, at the first edge where `pending` is set and the addressed lane is at its safe point:
  - lane `en`<=pending en, `div_r`<=pending div, `cnt`<=0, `out`<=0;
  - `pending`<=0.
  - The apply overrides the normal counter update in that cycle.
- Latency:
  - Accept at edge t; apply no earlier than edge t+1.
  - A disabled target applies at exactly t+1.
  - An enabled target applies within 2*(D_old+1) cycles.
  - `cfg_ready_o` returns to 1 the cycle after apply.
- Post-apply waveform:
  - After apply, the lane starts a low phase of D_new+1 cycles.
  - The output never shows a phase shorter than min(D_old, D_new)+1 cycles.
  - A disabling apply leaves `out` low.
- Boundary conditions:
  - Re-configuring an enabled lane with the same values still waits for its safe point. Phase is unchanged because apply coincides with the natural fall.
  - A lane select ≥ `width_p` (non-power-of-2 `width_p`) is accepted and silently dropped: `pending` clears at the next edge.
  - Only one configuration is outstanding at a time, so there is no simultaneous accept/apply conflict.
  - Lanes not addressed by the pending configuration are never disturbed.
  - D = 2^`div_width_p` − 1 is legal; `cnt` never exceeds `div_r`, so no wrap-around is needed.
  - Reset mid-operation: outputs drop to 0 asynchronously. A runt pulse is permitted here only.

Decomposition:
- Shared package `bsg_clk_div_pkg`: the packed struct `bsg_clk_div_cfg_s` {`en`, `div`} and the default lane count constant.
- One natural sub-module, `bsg_clk_div_lane`. It holds `en`/`div_r`/`cnt`/`out`, takes an apply strobe plus cfg, and outputs `clk_o` and `safe_o`.
- Top level: generate `width_p` lanes, plus the pending register and lane decode.

Test Plan:
- Reset then idle: `clk_o`=16'h0000 and `cfg_ready_o`=1 during and after reset.
- Enable from disabled: cfg lane 3, en=1, D=2 accepted at cycle 0 → apply at edge 1, `cfg_ready_o` low for exactly 1 cycle. `clk_o[3]` is then low 3 / high 3 repeatedly (period 6); all other bits stay 0.
- Retune on the fly: lane 3 at D=2, send D=0 during the high phase → the high phase completes its full 3 cycles, then period 2; `cfg_ready_o` is low until apply.
- Back-to-back: `cfg_v_i` held high with cfg A (lane 5, D=7) then cfg B (lane 5, D=1) → B is not accepted until the cycle after A applies. A and B take effect at successive safe points; there is no phase under 2 cycles.
- Disable: lane 5 at D=7, en=0 sent → `out` finishes its high phase of 8 cycles, falls, then stays 0; `cnt` is 0.
- Max divide: D=255 on lane 15 → period 512 cycles. Assert `reset_n_i`=0 mid-high-phase → `clk_o[15]` goes to 0 immediately, asynchronously, and stays 0 after release.
